// File: rtl/force_pipeline_arbiter.sv
// Purpose: round-robin share of one force pipeline among NUM_REQ pair-filter requesters,
//          with a timestep sequencer (IDLE -> RUN -> DRAIN -> DONE).
// Latency: 1 cycle from req_valid & req_ready to pipe_pkt.
// Backpressure: stall blocks every grant (req_ready all zero) and a null bubble is issued instead.
module force_pipeline_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DRAIN_CYCLES = 8,
    parameter int CNT_W        = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stall,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*226-1:0]   req_pair,
    input  logic [NUM_REQ-1:0]       req_done,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [226:0]             pipe_pkt,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         pair_count
);

    localparam int PAIR_W = 226;
    localparam int PKT_W  = PAIR_W + 1;
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

    // Null bubble: flag bit set, payload zero
    localparam logic [PKT_W-1:0] NULL_PKT = {1'b1, {PAIR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [PTR_W-1:0]    r_rr_ptr;
    logic [NUM_REQ-1:0]  r_done_seen;
    logic [DCNT_W-1:0]   r_drain_cnt;
    logic [PKT_W-1:0]    r_pipe_pkt;
    logic [CNT_W-1:0]    r_pair_count;
    logic                r_busy;
    logic                r_done;

    logic [NUM_REQ-1:0]  w_eligible;
    logic [NUM_REQ-1:0]  w_grant;
    logic                w_found;
    logic [PTR_W-1:0]    w_gidx;
    logic [PTR_W-1:0]    w_next_ptr;
    logic [PAIR_W-1:0]   w_sel_pair;
    logic                w_xfer;
    logic [NUM_REQ-1:0]  w_seen_next;
    logic                w_all_done;

    // Position k steps past the round-robin pointer, wrapped to the requester range
    function automatic int wrap_idx(input int base, input int k);
        return (base + k) % NUM_REQ;
    endfunction

    // Requesters that may be granted this cycle: only in RUN, not finished, no stall
    always_comb begin
        w_eligible = '0;
        if (r_state == S_RUN && !stall) begin
            w_eligible = req_valid & ~r_done_seen;
        end
    end

    // Round-robin search starting at r_rr_ptr; first eligible index wins
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && w_eligible[wrap_idx(int'(r_rr_ptr), k)]) begin
                w_found = 1'b1;
                w_gidx  = PTR_W'(wrap_idx(int'(r_rr_ptr), k));
            end
        end
    end

    // One-hot grant and the payload of the granted requester
    always_comb begin
        w_grant    = '0;
        w_sel_pair = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_found && (w_gidx == PTR_W'(i))) begin
                w_grant[i] = 1'b1;
                w_sel_pair = req_pair[PAIR_W*i +: PAIR_W];
            end
        end
    end

    // Pointer moves to the requester after the granted one, wrapping at NUM_REQ
    always_comb begin
        if (w_gidx == PTR_W'(NUM_REQ - 1)) begin
            w_next_ptr = '0;
        end else begin
            w_next_ptr = w_gidx + PTR_W'(1);
        end
    end

    // A requester finishing in this cycle still counts toward the all-done test
    always_comb begin
        w_xfer      = |(req_valid & w_grant);
        w_seen_next = r_done_seen | req_done;
        w_all_done  = &w_seen_next;
    end

    // Timestep sequencer, arbitration state and registered pipeline packet
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_done_seen  <= '0;
            r_drain_cnt  <= '0;
            r_pipe_pkt   <= NULL_PKT;
            r_pair_count <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_pipe_pkt <= NULL_PKT;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state      <= S_RUN;
                        r_rr_ptr     <= '0;
                        r_done_seen  <= '0;
                        r_pair_count <= '0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_xfer) begin
                        r_pipe_pkt <= {1'b0, w_sel_pair};
                        r_rr_ptr   <= w_next_ptr;
                        if (r_pair_count != {CNT_W{1'b1}}) begin
                            r_pair_count <= r_pair_count + CNT_W'(1);
                        end
                    end
                    r_done_seen <= w_seen_next;
                    if (w_all_done) begin
                        r_state     <= S_DRAIN;
                        r_drain_cnt <= DCNT_W'(DRAIN_CYCLES - 1);
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == '0) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - DCNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = w_grant;
    assign pipe_pkt   = r_pipe_pkt;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pair_count = r_pair_count;

endmodule

// File: doc/force_pipeline_arbiter.md
Name: force_pipeline_arbiter

Overview:
Shares one force pipeline between NUM_REQ pair-filter requesters using round-robin arbitration and a valid/ready handshake. Builds the 227-bit pipeline input packet and inserts null bubbles when no pair is issued. Sequences a timestep as IDLE -> RUN -> DRAIN -> DONE, so the downstream force accumulator knows when the pipeline holds no in-flight pairs.

Parameters:
NUM_REQ, 4, number of pair-filter requesters (2..16)
DRAIN_CYCLES, 8, cycles to wait after the last issue so the pipeline empties (>=1)
CNT_W, 32, width of the issued-pair counter

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin a timestep; sampled in IDLE or DONE only
stall  in  1  downstream back-pressure; blocks all grants while high
req_valid  in  NUM_REQ  requester i has a pair on req_pair[i]
req_pair  in  NUM_REQ*226  per requester: {idB[16:0], posB[95:0], idA[16:0], posA[95:0]}; requester i occupies bits [226*i +: 226]
req_done  in  NUM_REQ  requester i has no further pairs this timestep (pulse or level)
req_ready  out  NUM_REQ  one-hot grant, combinational
pipe_pkt  out  227  registered pipeline input: bit 226 = null flag; bits 225:0 = pair
busy  out  1  high in RUN or DRAIN
done  out  1  high in DONE
pair_count  out  CNT_W  pairs issued since the last start

Behaviour:
- Reset, applied on any cycle including mid-RUN or mid-DRAIN:
  - state = IDLE, pipe_pkt = {1'b1, 226'b0}, rr_ptr = 0, done_seen = 0, pair_count = 0, busy = 0, done = 0.
  - No transfer is counted in the reset cycle.
- Null packet: {1'b1, 226'b0}, driven on every cycle without an issue.
- IDLE:
  - req_ready = 0; pipe_pkt null.
  - start=1 -> RUN at the next edge; clears done_seen, pair_count and rr_ptr.
- RUN:
  - Eligible[i] = req_valid[i] & ~done_seen[i] & ~stall.
  - Grant goes to the first eligible index searching rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
  - req_ready is that one-hot grant, or 0 if nothing is eligible.
  - Transfer = valid & ready. On a transfer:
    - pipe_pkt <= {1'b0, req_pair[g]} at the next edge, so latency is 1 cycle;
    - rr_ptr <= (g+1) mod NUM_REQ;
    - pair_count increments and saturates at all-ones.
  - No transfer: pipe_pkt <= null and rr_ptr is unchanged. Stall never moves rr_ptr.
  - done_seen <= done_seen | req_done; bits are sticky.
  - A requester asserting req_valid and req_done in the same cycle may still be granted that cycle; it is masked from the next cycle on.
  - When (done_seen | req_done) is all ones at an edge, the state goes to DRAIN at that edge. A transfer in that same cycle still issues.
  - start is ignored in RUN.
- DRAIN:
  - req_ready = 0; pipe_pkt null.
  - drain_cnt is loaded with DRAIN_CYCLES-1 on entry and decrements each cycle.
  - At drain_cnt == 0 the state goes to DONE, so DRAIN lasts exactly DRAIN_CYCLES cycles.
  - stall and start are ignored.
- DONE:
  - done = 1; pipe_pkt null; pair_count held.
  - start=1 -> RUN next edge, with the same clears as from IDLE; done drops at that edge.
- busy and done are registered state decodes, never both high.
- req_pair bits are ignored unless granted. pipe_pkt bit 226 = 0 only in the cycle after a transfer.

Test Plan:
- Reset then start, with req0 valid for 3 pairs (posA=96'h1, idA=17'd5, posB=96'h2, idB=17'd9, etc.) -> pipe_pkt = {1'b0, idB, posB, idA, posA} one cycle after each handshake; pair_count = 3; null packet otherwise.
- All 4 requesters hold valid for 8 cycles -> grants 0,1,2,3,0,1,2,3; every pipe_pkt non-null; pair_count = 8.
- Requester 2 idle, stall=1 for cycles 3-5 -> req_ready = 0 and pipe_pkt null during stall; rotation resumes at the saved rr_ptr; no pair lost or duplicated.
- req_done pulses arrive at different cycles, with the last coinciding with a final transfer -> that pair issues; busy stays high exactly DRAIN_CYCLES = 8 cycles after entry to DRAIN; done = 1 after; start in DRAIN is ignored.
- Assert reset mid-RUN after 5 issues -> next cycle state IDLE, pipe_pkt null, pair_count = 0, req_ready = 0.
- From DONE, pulse start -> done = 0 and busy = 1 next cycle; pair_count = 0; arbitration restarts at requester 0.
